// File: rtl/hist_pkg.sv
// Shared types and sizing helpers for the histogram / CDF engine.
package hist_pkg;

  // Engine phases: pixel accumulation, CDF sweep, result hold.
  typedef enum logic [1:0] {
    ACC   = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2
  } stateT;

  localparam int DEFAULT_PIX_W   = 8;
  localparam int DEFAULT_COUNT_W = 15;

  // Width of the running CDF and frame total. A full frame of saturated bins
  // sums to at most 2**pix_w * (2**count_w - 1), which always fits here.
  function automatic int cum_w(input int count_w, input int pix_w);
    return count_w + pix_w;
  endfunction

endpackage

// File: rtl/histogram_cdf_engine_if.sv
// Pixel stream, frame control and result bus of the histogram / CDF engine.
interface histogram_cdf_engine_if
  import hist_pkg::*;
#(
  parameter int PIX_W   = DEFAULT_PIX_W,
  parameter int COUNT_W = DEFAULT_COUNT_W
) ();

  localparam int NUM_BINS = 2 ** PIX_W;
  localparam int CUM_W    = cum_w(COUNT_W, PIX_W);

  logic [PIX_W-1:0]    pix_data;
  logic                pix_valid;
  logic                pix_ready;
  logic                frame_start;
  logic                frame_end;
  logic [CUM_W-1:0]    threshold;
  logic                busy;
  logic                done;
  logic [NUM_BINS-1:0] cdf_mask;
  logic [PIX_W-1:0]    pct_bin;
  logic                pct_found;
  logic [CUM_W-1:0]    total;

  // Pixel source / frame controller side.
  modport master (
    output pix_data, pix_valid, frame_start, frame_end, threshold,
    input  pix_ready, busy, done, cdf_mask, pct_bin, pct_found, total
  );

  // Engine side.
  modport slave (
    input  pix_data, pix_valid, frame_start, frame_end, threshold,
    output pix_ready, busy, done, cdf_mask, pct_bin, pct_found, total
  );

endinterface

// File: rtl/hist_bin_counter.sv
// One histogram bin: saturating event counter with a frame-zero input.
// When zero and inc arrive together the bin restarts at 1, so the pixel that
// coincides with the start of a frame is not lost.
module hist_bin_counter
  import hist_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               zero,
  input  logic               inc,
  output logic [COUNT_W-1:0] q
);

  localparam logic [COUNT_W-1:0] MAX_COUNT = '1;

  logic [COUNT_W-1:0] countReg;

  // Count accepted pixels, holding at full scale instead of wrapping.
  always_ff @(posedge clk) begin
    if (clear) begin
      countReg <= '0;
    end else if (zero) begin
      countReg <= inc ? COUNT_W'(1) : '0;
    end else if (inc && (countReg != MAX_COUNT)) begin
      countReg <= countReg + COUNT_W'(1);
    end
  end

  assign q = countReg;

endmodule

// File: rtl/histogram_cdf_engine.sv
// Histogram and CDF engine for the image-intensity path.
// Pixels are binned into NUM_BINS saturating counters. On frame end a single
// shared adder/comparator walks the bins one per cycle, building the running
// CDF into shadow registers; the visible results are updated all at once,
// together with a one-cycle done pulse, when the walk completes.
module histogram_cdf_engine
  import hist_pkg::*;
#(
  parameter int PIX_W   = DEFAULT_PIX_W,
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input logic                   clk,
  input logic                   clear,
  histogram_cdf_engine_if.slave bus
);

  localparam int               NUM_BINS = 2 ** PIX_W;
  localparam int               CUM_W    = cum_w(COUNT_W, PIX_W);
  localparam logic [PIX_W-1:0] LAST_IDX = '1;

  stateT               stateReg;
  logic                pixAccept;
  logic                zeroBins;
  logic                frameEndAccept;
  logic [NUM_BINS-1:0] binInc;
  logic [COUNT_W-1:0]  binQ [NUM_BINS];

  logic [PIX_W-1:0]    sweepIdxReg;
  logic [CUM_W-1:0]    thrReg;
  logic [CUM_W-1:0]    cumReg;
  logic [CUM_W-1:0]    cumNext;
  logic                crossNow;
  logic [NUM_BINS-1:0] shadowMaskReg;
  logic [NUM_BINS-1:0] shadowMaskNext;
  logic [PIX_W-1:0]    shadowPctReg;
  logic [PIX_W-1:0]    shadowPctNext;
  logic                shadowFoundReg;
  logic                shadowFoundNext;

  logic                pixReadyReg;
  logic                busyReg;
  logic                doneReg;
  logic [NUM_BINS-1:0] cdfMaskReg;
  logic [PIX_W-1:0]    pctBinReg;
  logic                pctFoundReg;
  logic [CUM_W-1:0]    totalReg;

  // Decode which events the current state honours; frame_start beats frame_end.
  always_comb begin
    pixAccept      = (stateReg == ACC) && bus.pix_valid;
    zeroBins       = bus.frame_start && ((stateReg == ACC) || (stateReg == HOLD));
    frameEndAccept = (stateReg == ACC) && bus.frame_end && !bus.frame_start;
  end

  // Bin bank: each bin recognises its own intensity code.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BINS; gi++) begin : gBin
      assign binInc[gi] = pixAccept && (bus.pix_data == PIX_W'(gi));

      hist_bin_counter #(
        .COUNT_W(COUNT_W)
      ) uBin (
        .clk  (clk),
        .clear(clear),
        .zero (zeroBins),
        .inc  (binInc[gi]),
        .q    (binQ[gi])
      );
    end
  endgenerate

  // Shared sweep datapath: add bin k to the running sum and test it.
  always_comb begin
    cumNext         = cumReg + CUM_W'(binQ[sweepIdxReg]);
    crossNow        = (cumNext >= thrReg);
    shadowMaskNext  = shadowMaskReg;
    shadowMaskNext[sweepIdxReg] = crossNow;
    shadowPctNext   = shadowPctReg;
    shadowFoundNext = shadowFoundReg;
    if (crossNow && !shadowFoundReg) begin
      shadowPctNext   = sweepIdxReg;
      shadowFoundNext = 1'b1;
    end
  end

  // Frame sequencing ACC -> SWEEP -> HOLD -> ACC with registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      stateReg       <= ACC;
      sweepIdxReg    <= '0;
      thrReg         <= '0;
      cumReg         <= '0;
      shadowMaskReg  <= '0;
      shadowPctReg   <= '0;
      shadowFoundReg <= 1'b0;
      pixReadyReg    <= 1'b1;
      busyReg        <= 1'b0;
      doneReg        <= 1'b0;
      cdfMaskReg     <= '0;
      pctBinReg      <= '0;
      pctFoundReg    <= 1'b0;
      totalReg       <= '0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        ACC: begin
          if (frameEndAccept) begin
            thrReg         <= bus.threshold;
            cumReg         <= '0;
            sweepIdxReg    <= '0;
            shadowMaskReg  <= '0;
            shadowPctReg   <= '0;
            shadowFoundReg <= 1'b0;
            pixReadyReg    <= 1'b0;
            busyReg        <= 1'b1;
            stateReg       <= SWEEP;
          end
        end
        SWEEP: begin
          cumReg         <= cumNext;
          shadowMaskReg  <= shadowMaskNext;
          shadowPctReg   <= shadowPctNext;
          shadowFoundReg <= shadowFoundNext;
          sweepIdxReg    <= sweepIdxReg + PIX_W'(1);
          if (sweepIdxReg == LAST_IDX) begin
            // Publish the completed sweep, including the last bin just summed.
            cdfMaskReg  <= shadowMaskNext;
            pctBinReg   <= shadowPctNext;
            pctFoundReg <= shadowFoundNext;
            totalReg    <= cumNext;
            doneReg     <= 1'b1;
            busyReg     <= 1'b0;
            stateReg    <= HOLD;
          end
        end
        HOLD: begin
          if (bus.frame_start) begin
            pixReadyReg <= 1'b1;
            stateReg    <= ACC;
          end
        end
        default: begin
          stateReg <= ACC;
        end
      endcase
    end
  end

  assign bus.pix_ready = pixReadyReg;
  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;
  assign bus.cdf_mask  = cdfMaskReg;
  assign bus.pct_bin   = pctBinReg;
  assign bus.pct_found = pctFoundReg;
  assign bus.total     = totalReg;

endmodule

// File: tb/tb_histogram_cdf_engine.sv
// Self-checking bench for histogram_cdf_engine: directed frames plus random
// frames, compared every cycle against a frame-level behavioural model.
module tb_histogram_cdf_engine;
  import hist_pkg::*;

  localparam int PIX_W    = 8;
  localparam int COUNT_W  = 15;
  localparam int NUM_BINS = 256;
  localparam int CUM_W    = 23;
  localparam int SAT      = 32767;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  histogram_cdf_engine_if #(.PIX_W(PIX_W), .COUNT_W(COUNT_W)) bus ();

  histogram_cdf_engine #(.PIX_W(PIX_W), .COUNT_W(COUNT_W)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus.slave)
  );

  int passCount = 0;
  int checkCount = 0;

  task automatic check(input string name, input logic [NUM_BINS-1:0] act,
                       input logic [NUM_BINS-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int                  mBins [NUM_BINS];
  int                  mPhase = 0;   // 0 accumulate, 1 sweeping, 2 holding
  int                  mLeft = 0;
  longint              mThr = 0;
  longint              mCum;
  logic                eReady = 1'b1, eBusy = 1'b0, eDone = 1'b0, eFound = 1'b0;
  logic [NUM_BINS-1:0] eMask = '0;
  int                  ePct = 0;
  longint              eTotal = 0;

  always @(posedge clk) begin
    eDone = 1'b0;
    if (clear) begin
      foreach (mBins[i]) mBins[i] = 0;
      mPhase = 0;
      eMask = '0; ePct = 0; eFound = 1'b0; eTotal = 0;
    end else begin
      case (mPhase)
        0: begin
          if (bus.frame_start) foreach (mBins[i]) mBins[i] = 0;
          if (bus.pix_valid && mBins[bus.pix_data] < SAT) mBins[bus.pix_data]++;
          if (bus.frame_end && !bus.frame_start) begin
            mThr = longint'(bus.threshold);
            mPhase = 1;
            mLeft = NUM_BINS;
          end
        end
        1: begin
          mLeft--;
          if (mLeft == 0) begin
            mCum = 0; eMask = '0; eFound = 1'b0; ePct = 0;
            for (int i = 0; i < NUM_BINS; i++) begin
              mCum += mBins[i];
              if (mCum >= mThr) begin
                eMask[i] = 1'b1;
                if (!eFound) begin eFound = 1'b1; ePct = i; end
              end
            end
            eTotal = mCum;
            eDone = 1'b1;
            mPhase = 2;
          end
        end
        default: begin
          if (bus.frame_start) begin
            foreach (mBins[i]) mBins[i] = 0;
            mPhase = 0;
          end
        end
      endcase
    end
    eReady = (mPhase == 0);
    eBusy  = (mPhase == 1);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("pix_ready", NUM_BINS'(bus.pix_ready), NUM_BINS'(eReady));
    check("busy",      NUM_BINS'(bus.busy),      NUM_BINS'(eBusy));
    check("done",      NUM_BINS'(bus.done),      NUM_BINS'(eDone));
    check("cdf_mask",  bus.cdf_mask,             eMask);
    check("pct_bin",   NUM_BINS'(bus.pct_bin),   NUM_BINS'(ePct));
    check("pct_found", NUM_BINS'(bus.pct_found), NUM_BINS'(eFound));
    check("total",     NUM_BINS'(bus.total),     NUM_BINS'(eTotal));
  end

  // ---------------- stimulus helpers ----------------
  task automatic sendPix(input int v);
    bus.pix_valid = 1'b1;
    bus.pix_data  = PIX_W'(v);
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic startFrame(input bit withPix, input int v);
    bus.frame_start = 1'b1;
    bus.pix_valid   = withPix;
    bus.pix_data    = PIX_W'(v);
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
  endtask

  task automatic endFrame(input longint thr, input bit withPix, input int v);
    bus.frame_end = 1'b1;
    bus.threshold = CUM_W'(thr);
    bus.pix_valid = withPix;
    bus.pix_data  = PIX_W'(v);
    @(negedge clk);
    bus.frame_end = 1'b0;
    bus.pix_valid = 1'b0;
  endtask

  // Wait (bounded) for done; optionally drive junk that the sweep must ignore.
  task automatic waitDone(input bit noise, output int lat);
    lat = 1;
    while (!bus.done && lat < 400) begin
      if (noise) begin
        bus.pix_valid = 1'($urandom_range(0, 1));
        bus.pix_data  = PIX_W'($urandom);
        bus.frame_end = 1'($urandom_range(0, 1));
        bus.threshold = CUM_W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus.pix_valid = 1'b0;
    bus.frame_end = 1'b0;
    checkCount++;
    if (bus.done) passCount++;
    else $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
  endtask

  task automatic report(input string tag, input int lat);
    $display("frame %s: total=%0d pct_bin=%0d pct_found=%0b latency=%0d",
             tag, bus.total, bus.pct_bin, bus.pct_found, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random tests ----------------
  initial begin
    int lat;
    int n;
    int lo;
    int hi;
    bit sawDone;
    logic [NUM_BINS-1:0] expMask;

    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.frame_start = 1'b0;
    bus.frame_end = 1'b0; bus.threshold = '0;
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    check("rst_pix_ready", NUM_BINS'(bus.pix_ready), NUM_BINS'(1));
    check("rst_busy",      NUM_BINS'(bus.busy),      NUM_BINS'(0));
    check("rst_total",     NUM_BINS'(bus.total),     NUM_BINS'(0));
    check("rst_mask",      bus.cdf_mask,             NUM_BINS'(0));
    $display("reset released");

    // 1. clear in the middle of a sweep
    startFrame(1'b0, 0);
    for (int i = 0; i < 10; i++) sendPix(i * 7);
    endFrame(5, 1'b0, 0);
    repeat (50) @(negedge clk);
    check("sweep_busy", NUM_BINS'(bus.busy), NUM_BINS'(1));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort_pix_ready", NUM_BINS'(bus.pix_ready), NUM_BINS'(1));
    check("abort_busy",      NUM_BINS'(bus.busy),      NUM_BINS'(0));
    check("abort_total",     NUM_BINS'(bus.total),     NUM_BINS'(0));
    sawDone = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    check("abort_no_done", NUM_BINS'(sawDone), NUM_BINS'(0));
    $display("frame abort: cleared mid-sweep, done seen=%0b", sawDone);

    // 2. uniform ramp
    startFrame(1'b0, 0);
    for (int i = 0; i < NUM_BINS; i++) sendPix(i);
    endFrame(128, 1'b0, 0);
    waitDone(1'b0, lat);
    expMask = '0;
    for (int i = 127; i < NUM_BINS; i++) expMask[i] = 1'b1;
    check("ramp_latency", NUM_BINS'(lat),           NUM_BINS'(257));
    check("ramp_total",   NUM_BINS'(bus.total),     NUM_BINS'(256));
    check("ramp_pct",     NUM_BINS'(bus.pct_bin),   NUM_BINS'(127));
    check("ramp_found",   NUM_BINS'(bus.pct_found), NUM_BINS'(1));
    check("ramp_mask",    bus.cdf_mask,             expMask);
    report("ramp", lat);

    // 3. saturation (frame start from HOLD: that pixel is not counted)
    startFrame(1'b1, 5);
    bus.pix_valid = 1'b1;
    bus.pix_data  = PIX_W'(5);
    repeat (40000) @(negedge clk);
    bus.pix_valid = 1'b0;
    endFrame(32767, 1'b0, 0);
    waitDone(1'b1, lat);
    check("sat_total", NUM_BINS'(bus.total),     NUM_BINS'(32767));
    check("sat_pct",   NUM_BINS'(bus.pct_bin),   NUM_BINS'(5));
    check("sat_found", NUM_BINS'(bus.pct_found), NUM_BINS'(1));
    report("saturate", lat);

    // 4. unreachable, then zero threshold
    startFrame(1'b0, 0);
    for (int i = 0; i < 10; i++) sendPix(200);
    endFrame(11, 1'b0, 0);
    waitDone(1'b1, lat);
    check("unreach_found", NUM_BINS'(bus.pct_found), NUM_BINS'(0));
    check("unreach_mask",  bus.cdf_mask,             NUM_BINS'(0));
    check("unreach_pct",   NUM_BINS'(bus.pct_bin),   NUM_BINS'(0));
    check("unreach_total", NUM_BINS'(bus.total),     NUM_BINS'(10));
    report("unreachable", lat);
    startFrame(1'b0, 0);
    for (int i = 0; i < 10; i++) sendPix(200);
    endFrame(0, 1'b0, 0);
    waitDone(1'b1, lat);
    expMask = '1;
    check("zero_mask",  bus.cdf_mask,             expMask);
    check("zero_pct",   NUM_BINS'(bus.pct_bin),   NUM_BINS'(0));
    check("zero_found", NUM_BINS'(bus.pct_found), NUM_BINS'(1));
    report("zero_thr", lat);

    // 5. simultaneous events
    startFrame(1'b0, 0);
    for (int i = 0; i < 4; i++) sendPix(50);
    bus.frame_start = 1'b1; bus.frame_end = 1'b1; bus.threshold = CUM_W'(1);
    bus.pix_valid = 1'b1; bus.pix_data = PIX_W'(7);
    @(negedge clk);
    bus.frame_start = 1'b0; bus.frame_end = 1'b0; bus.pix_valid = 1'b0;
    check("fs_fe_ready", NUM_BINS'(bus.pix_ready), NUM_BINS'(1));
    sendPix(9);
    endFrame(2, 1'b1, 3);
    waitDone(1'b1, lat);
    check("simul_total", NUM_BINS'(bus.total),   NUM_BINS'(3));
    check("simul_pct",   NUM_BINS'(bus.pct_bin), NUM_BINS'(7));
    report("simultaneous", lat);

    // 6. back-to-back random frames; held results are checked every cycle
    for (int f = 0; f < 6; f++) begin
      startFrame(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      n  = int'($urandom_range(1, 500));
      lo = int'($urandom_range(0, 200));
      hi = lo + int'($urandom_range(0, 55));
      for (int i = 0; i < n; i++) begin
        bus.pix_valid = 1'($urandom_range(0, 3) != 0);
        bus.pix_data  = PIX_W'($urandom_range(lo, hi));
        @(negedge clk);
      end
      bus.pix_valid = 1'b0;
      endFrame(longint'($urandom_range(0, n + 4)), 1'($urandom_range(0, 1)),
               int'($urandom_range(lo, hi)));
      waitDone(1'b1, lat);
      report($sformatf("random%0d", f), lat);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
